// File: rtl/mux_ctrl_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
package mux_ctrl_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
        onehot = '0;
        onehot[i] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request after the last owner.
module rr_pick4
    import mux_ctrl_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] lp,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan farthest-first so the nearest candidate after lp wins.
    always_comb begin
        valid = |req;
        idx   = lp;
        cand  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = lp + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 single-bit mux with a bounded hold time.
module mux4_rr_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    input  logic [N_REQ-1:0] w,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] s,
    output logic             out,
    output logic             busy,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] LIM =
        CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic [SEL_W-1:0] lp_q, lp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;
    logic             rel_vol;
    logic             rel_lim;

    rr_pick4 u_pick (
        .req   (req),
        .lp    (lp_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // In GRANT, s_q always names the current owner.
    assign rel_vol = done | ~req[s_q];
    assign rel_lim = (MAX_HOLD != 0) && (cnt_q == LIM);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        s_d       = s_q;
        lp_d      = lp_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                gnt_d  = '0;
                out_d  = 1'b0;
                busy_d = 1'b0;
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot(pick_idx);
                    s_d     = pick_idx;
                    lp_d    = pick_idx;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_GRANT: begin
                out_d = w[s_q];
                if (rel_vol || rel_lim) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    out_d     = 1'b0;
                    cnt_d     = '0;
                    timeout_d = rel_lim & ~rel_vol;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            s_q       <= '0;
            lp_q      <= SEL_W'(N_REQ - 1);
            cnt_q     <= '0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            s_q       <= s_d;
            lp_q      <= lp_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign s       = s_q;
    assign out     = out_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4-to-1, 1-bit mux datapath.
- Four requesters each own one data input w[i]; the block grants one requester at a time and drives the mux select s.
- It registers the selected bit to out.
- It also bounds how long any one requester may hold the mux.
- Sits between requester logic and the shared single-bit output line.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one owner may hold the grant. 0 disables the timeout.
- CNT_W, 4: hold-counter width. Must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester; bit i = requester i.
- done  input  1  current owner releases the grant (sampled only in GRANT).
- w  input  4  data bit per requester; w[i] belongs to requester i.
- gnt  output  4  one-hot grant, or all zero.
- s  output  2  mux select = index of current or last owner. s[1] is MSB.
- out  output  1  registered mux output.
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (asynchronous, takes effect immediately while rst_n = 0):
  - gnt=0000, s=00, out=0, busy=0, timeout=0.
  - state=IDLE, hold counter=0, last-owner pointer lp=3, so requester 0 has first priority.
- States: IDLE, GRANT. Two-state FSM, all outputs registered.
- IDLE:
  - If req != 0 at an edge, go to GRANT. Owner = first set bit scanning lp+1, lp+2, lp+3, lp (mod 4).
  - On that edge: gnt = one-hot(owner), s = owner, busy=1, counter=0, lp = owner.
  - Grant is visible the cycle after req is sampled (1-cycle latency).
  - If req = 0, stay in IDLE. gnt=0000 and out=0; s holds its last value.
- GRANT:
  - Each edge: out <= w[s]. Data latency is 1 cycle from w to out.
  - Release condition at an edge: done=1, OR req[owner]=0, OR (MAX_HOLD != 0 and counter == MAX_HOLD-1).
  - On release: go to IDLE, gnt=0000, busy=0, out=0, counter=0.
  - Otherwise: counter+1.
  - The grant therefore lasts at most MAX_HOLD cycles.
- timeout:
  - Asserted for exactly the one cycle after a release caused only by the counter limit.
  - If done=1 or req[owner]=0 coincides with the limit, the release is voluntary and timeout stays 0.
- Dead cycle:
  - Every release passes through at least one IDLE cycle before the next grant.
  - gnt never changes directly from one one-hot value to another.
- Fairness: lp is updated only on grant. A releasing owner has lowest priority at the next arbitration.
- req changes on non-owner bits during GRANT have no effect.
- done while in IDLE is ignored.
- gnt is always one-hot or zero. busy == |gnt.
- Reset asserted mid-grant aborts immediately. After rst_n rises, arbitration restarts with requester 0 at highest priority.

Decomposition:
- Shared package mux_ctrl_pkg holds:
  - N_REQ=4.
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Select width SEL_W=2.
- Sub-module rr_pick4: purely combinational.
  - Inputs: req[3:0], lp[1:0].
  - Outputs: valid, idx[1:0].
  - The top level instantiates it once.

Test Plan:
1. Reset: hold rst_n=0 with req=1111 and w=1111 -> gnt=0000, s=00, out=0, busy=0, timeout=0. Release reset with req=1111 -> first edge gives gnt=0001, s=00.
2. Single request: req=0100, w=0100 -> after edge k, gnt=0100, s=10, busy=1. After edge k+1, out=1. Pulse done=1 -> next edge gnt=0000, out=0, busy=0.
3. Round robin: req=1111 held, done pulsed in the first grant cycle of each owner -> gnt sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
4. Timeout: MAX_HOLD=8, req=0001 held, done=0 -> gnt=0001 for exactly 8 cycles, then timeout=1 for 1 cycle with gnt=0000. gnt=0001 again on the following edge.
5. Coincident release: MAX_HOLD=8, done=1 on the 8th grant cycle -> release with timeout=0. Separately, drop req[owner] mid-grant -> release next edge, timeout=0.
6. Async reset mid-grant: owner=2, counter=5, pull rst_n low between edges -> gnt, busy and out go to 0 before the next edge. After release with req=0101 -> grant goes to 0, not 2.
